noc_vc_tx_sched: RTL and testbench



---
 rtl/common_pkg.sv | 23 ++
 rtl/noc_if.sv | 29 ++
 rtl/noc_rr_arbiter.sv | 43 ++++
 rtl/noc_vc_tx_sched.sv | 99 +++++++++
 tb/tb_noc_vc_tx_sched.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/common_pkg.sv
// Shared NoC widths, credit defaults and the packet payload layout.
package common_pkg;

  localparam int DEFAULT_VC_W       = 2;
  localparam int DEFAULT_X_W        = 4;
  localparam int DEFAULT_Y_W        = 4;
  localparam int DEFAULT_D_W        = 16;
  localparam int DEFAULT_VC_CREDITS = 4;

  localparam int NOC_PKT_W = DEFAULT_D_W + DEFAULT_X_W + DEFAULT_Y_W;

  // Field order matches the flattened req_packet slices: data in the MSBs, x in the LSBs.
  typedef struct packed {
    logic [DEFAULT_D_W-1:0] data;
    logic [DEFAULT_Y_W-1:0] y;
    logic [DEFAULT_X_W-1:0] x;
  } noc_packet_s;

  function automatic int noc_pkt_w(input int d_w, input int x_w, input int y_w);
    return d_w + x_w + y_w;
  endfunction

endpackage

// File: rtl/noc_if.sv
// One NoC link: VC-tagged packet downstream, per-VC credit returns upstream.
interface noc_if
  import common_pkg::*;
#(
  parameter int VC_W = DEFAULT_VC_W,
  parameter int X_W  = DEFAULT_X_W,
  parameter int Y_W  = DEFAULT_Y_W,
  parameter int D_W  = DEFAULT_D_W
);

  localparam int PKT_W = noc_pkt_w(D_W, X_W, Y_W);

  logic [VC_W-1:0]  vc_target;
  logic [PKT_W-1:0] packet;
  logic [VC_W-1:0]  vc_credit_gnt;

  modport transmitter (
    output vc_target,
    output packet,
    input  vc_credit_gnt
  );

  modport receiver (
    input  vc_target,
    input  packet,
    output vc_credit_gnt
  );

endinterface

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter: one-hot0 grant, combinational from req; pointer moves past the winner on advance.
module noc_rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [N-1:0]     req_rot;
  logic [N-1:0]     pick;
  logic [2*N-1:0]   gnt_dbl;

  // Rotate so the pointer VC sits at bit 0, take the lowest set bit, rotate back.
  assign req_rot = N'({req, req} >> ptr);
  assign pick    = req_rot & (~req_rot + N'(1));
  assign gnt_dbl = {{N{1'b0}}, pick} << ptr;
  assign gnt     = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];

  always_comb begin
    ptr_nxt = ptr;
    for (int v = 0; v < N; v++) begin
      if (gnt[v]) begin
        ptr_nxt = (v == N - 1) ? '0 : PTR_W'(v + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && |gnt) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/noc_vc_tx_sched.sv
// Credit-based VC transmit scheduler: round-robin over VCs holding credit, one packet per cycle,
// registered onto the link one cycle after req_ready.
module noc_vc_tx_sched
  import common_pkg::*;
#(
  parameter int VC_W    = DEFAULT_VC_W,
  parameter int X_W     = DEFAULT_X_W,
  parameter int Y_W     = DEFAULT_Y_W,
  parameter int D_W     = DEFAULT_D_W,
  parameter int CREDITS = DEFAULT_VC_CREDITS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [VC_W-1:0]                req_valid,
  output logic [VC_W-1:0]                req_ready,
  input  logic [VC_W*(D_W+X_W+Y_W)-1:0]  req_packet,
  noc_if.transmitter                     tx
);

  localparam int PKT_W = noc_pkt_w(D_W, X_W, Y_W);
  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);

  logic [CNT_W-1:0] cnt [VC_W];
  logic [VC_W-1:0]  elig;
  logic [VC_W-1:0]  gnt;
  logic [VC_W-1:0]  sent;
  logic [PKT_W-1:0] sel_pkt;

  always_comb begin
    for (int v = 0; v < VC_W; v++) begin
      elig[v] = req_valid[v] && (cnt[v] != '0);
    end
  end

  noc_rr_arbiter #(.N(VC_W)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (elig),
    .advance (|sent),
    .gnt     (gnt)
  );

  assign req_ready = rst ? '0 : gnt;
  assign sent      = req_ready & req_valid;

  always_comb begin
    sel_pkt = '0;
    for (int v = 0; v < VC_W; v++) begin
      if (gnt[v]) begin
        sel_pkt = req_packet[v*PKT_W +: PKT_W];
      end
    end
  end

  // A send and a credit return on the same VC cancel; a return with the counter full saturates.
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_W; v++) begin
      if (rst) begin
        cnt[v] <= CNT_MAX;
      end else if (sent[v] && !tx.vc_credit_gnt[v]) begin
        cnt[v] <= cnt[v] - CNT_W'(1);
      end else if (!sent[v] && tx.vc_credit_gnt[v] && (cnt[v] != CNT_MAX)) begin
        cnt[v] <= cnt[v] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx.vc_target <= '0;
      tx.packet    <= '0;
    end else begin
      tx.vc_target <= sent;
      if (|sent) begin
        tx.packet <= sel_pkt;
      end
    end
  end

`ifndef SYNTHESIS
  initial begin
    assert (CREDITS >= 1) else $fatal(1, "noc_vc_tx_sched: CREDITS must be >= 1");
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(req_ready)) else $error("noc_vc_tx_sched: req_ready not one-hot0");
      for (int v = 0; v < VC_W; v++) begin
        assert (cnt[v] <= CNT_MAX) else $error("noc_vc_tx_sched: credit count above CREDITS");
        assert (!(sent[v] && cnt[v] == '0)) else $error("noc_vc_tx_sched: send on zero-credit VC");
        assert (!(tx.vc_credit_gnt[v] && !sent[v] && cnt[v] == CNT_MAX))
          else $error("noc_vc_tx_sched: credit overflow");
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_vc_tx_sched.sv
// Bench for noc_vc_tx_sched: directed scenarios plus randomized traffic against a credit/round-robin model.
module tb_noc_vc_tx_sched;

  localparam int VC_W    = 2;
  localparam int X_W     = 4;
  localparam int Y_W     = 4;
  localparam int D_W     = 16;
  localparam int CREDITS = 4;
  localparam int PKT_W   = D_W + X_W + Y_W;
  localparam int PW      = VC_W * PKT_W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [VC_W-1:0] req_valid = '0;
  logic [VC_W-1:0] req_ready;
  logic [PW-1:0]   req_packet = '0;

  noc_if #(.VC_W(VC_W), .X_W(X_W), .Y_W(Y_W), .D_W(D_W)) tx_if ();

  noc_vc_tx_sched #(
    .VC_W(VC_W), .X_W(X_W), .Y_W(Y_W), .D_W(D_W), .CREDITS(CREDITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_packet (req_packet),
    .tx         (tx_if.transmitter)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: credits held per VC, which VC has top priority, and the expected link outputs.
  int               m_cnt [VC_W];
  int               m_ptr = 0;
  logic [VC_W-1:0]  m_tgt = '0;
  logic [PKT_W-1:0] m_pkt = '0;
  bit               m_init = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    int gi;
    int v;
    logic [VC_W-1:0] e_rdy;
    if (rst) begin
      check("rst_ready", 64'(req_ready), 64'd0);
      if (m_init) begin
        check("rst_vc_target", 64'(tx_if.vc_target), 64'(m_tgt));
        check("rst_packet", 64'(tx_if.packet), 64'(m_pkt));
      end
      for (int k = 0; k < VC_W; k++) m_cnt[k] = CREDITS;
      m_ptr  = 0;
      m_tgt  = '0;
      m_pkt  = '0;
      m_init = 1'b1;
    end else if (m_init) begin
      gi = -1;
      for (int i = 0; i < VC_W; i++) begin
        v = (m_ptr + i) % VC_W;
        if (gi < 0 && req_valid[v] && m_cnt[v] > 0) gi = v;
      end
      e_rdy = (gi >= 0) ? VC_W'(1 << gi) : '0;
      check("model_ready", 64'(req_ready), 64'(e_rdy));
      check("model_vc_target", 64'(tx_if.vc_target), 64'(m_tgt));
      check("model_packet", 64'(tx_if.packet), 64'(m_pkt));
      for (int k = 0; k < VC_W; k++) begin
        m_cnt[k] = m_cnt[k] - ((gi == k) ? 1 : 0) + (tx_if.vc_credit_gnt[k] ? 1 : 0);
        if (m_cnt[k] > CREDITS) m_cnt[k] = CREDITS;
      end
      if (gi >= 0) begin
        m_ptr = (gi + 1) % VC_W;
        m_pkt = req_packet[gi*PKT_W +: PKT_W];
      end
      m_tgt = e_rdy;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  // One reset cycle; the caller drives the first post-reset inputs right after.
  task automatic reset_link();
    rst = 1'b1;
    req_valid = '0;
    tx_if.vc_credit_gnt = '0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    logic [PKT_W-1:0] prev_sel;
    tx_if.vc_credit_gnt = '0;

    // Reset state and a lone VC0 requester draining its four credits.
    rst = 1'b1;
    req_valid = 2'b01;
    req_packet = {24'h2B2B2B, 24'h1A1A1A};
    repeat (2) cyc();
    mid();
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_vc_target", 64'(tx_if.vc_target), 64'd0);
    check("reset_packet", 64'(tx_if.packet), 64'd0);
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 7; c++) begin
      mid();
      check("t1_ready", 64'(req_ready), (c < 4) ? 64'd1 : 64'd0);
      check("t1_target", 64'(tx_if.vc_target), (c >= 1 && c <= 4) ? 64'd1 : 64'd0);
      if (c == 1) check("t1_packet", 64'(tx_if.packet), 64'h1A1A1A);
      cyc();
    end

    // Both VCs busy with credits returned as soon as they are owed: strict alternation from VC0.
    reset_link();
    req_valid = 2'b11;
    prev_sel = '0;
    for (int c = 0; c < 10; c++) begin
      req_packet = PW'({$urandom(), $urandom()});
      for (int k = 0; k < VC_W; k++) tx_if.vc_credit_gnt[k] = (m_cnt[k] < CREDITS);
      mid();
      check("t2_ready", 64'(req_ready), (c % 2 == 0) ? 64'd1 : 64'd2);
      if (c >= 1) check("t2_target", 64'(tx_if.vc_target), (c % 2 == 1) ? 64'd1 : 64'd2);
      check("t2_packet", 64'(tx_if.packet), 64'(prev_sel));
      prev_sel = (c % 2 == 0) ? req_packet[0 +: PKT_W] : req_packet[PKT_W +: PKT_W];
      cyc();
    end

    // VC0 at zero credits: a return in cycle N makes it ready in N+1 and sent in N+2.
    reset_link();
    req_valid = 2'b01;
    repeat (5) cyc();
    tx_if.vc_credit_gnt = 2'b01;
    mid();
    check("t3_ready_n", 64'(req_ready), 64'd0);
    cyc();
    tx_if.vc_credit_gnt = 2'b00;
    mid();
    check("t3_ready_n1", 64'(req_ready), 64'd1);
    cyc();
    mid();
    check("t3_target_n2", 64'(tx_if.vc_target), 64'd1);
    check("t3_ready_n2", 64'(req_ready), 64'd0);
    cyc();

    // VC1 at one credit: a send and a return together keep it at one.
    reset_link();
    req_valid = 2'b10;
    repeat (3) cyc();
    tx_if.vc_credit_gnt = 2'b10;
    mid();
    check("t4_send", 64'(req_ready), 64'd2);
    cyc();
    tx_if.vc_credit_gnt = 2'b00;
    mid();
    check("t4_still_elig", 64'(req_ready), 64'd2);
    cyc();
    mid();
    check("t4_empty", 64'(req_ready), 64'd0);
    cyc();

    // Both VCs drained, then one cycle returning a credit to each.
    reset_link();
    req_valid = 2'b11;
    repeat (8) cyc();
    tx_if.vc_credit_gnt = 2'b11;
    mid();
    check("t5_drained", 64'(req_ready), 64'd0);
    cyc();
    tx_if.vc_credit_gnt = 2'b00;
    mid();
    check("t5_vc0", 64'(req_ready), 64'd1);
    cyc();
    mid();
    check("t5_vc1", 64'(req_ready), 64'd2);
    check("t5_target0", 64'(tx_if.vc_target), 64'd1);
    cyc();
    mid();
    check("t5_done", 64'(req_ready), 64'd0);
    check("t5_target1", 64'(tx_if.vc_target), 64'd2);
    cyc();

    // Reset with counts at 1 and 3: full credits and VC0 priority afterwards.
    reset_link();
    req_valid = 2'b11;
    repeat (2) cyc();
    req_valid = 2'b01;
    repeat (2) cyc();
    rst = 1'b1;
    req_valid = 2'b11;
    mid();
    check("t6_rst_ready", 64'(req_ready), 64'd0);
    cyc();
    mid();
    check("t6_rst_target", 64'(tx_if.vc_target), 64'd0);
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 9; c++) begin
      mid();
      check("t6_ready", 64'(req_ready), (c >= 8) ? 64'd0 : ((c % 2 == 0) ? 64'd1 : 64'd2));
      cyc();
    end

    // Random traffic with credits returned only when the downstream actually owes them.
    reset_link();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      req_valid = VC_W'($urandom());
      req_packet = PW'({$urandom(), $urandom()});
      for (int k = 0; k < VC_W; k++) begin
        tx_if.vc_credit_gnt[k] = (m_cnt[k] < CREDITS) && ($urandom_range(0, 2) != 0);
      end
      cyc();
    end
    rst = 1'b0;
    req_valid = '0;
    tx_if.vc_credit_gnt = '0;
    cyc();
    mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
